// File: rtl/segment_transition_ctl_pkg.sv
// Shared types and constants for the double-buffered segment transition controller.
package segment_transition_ctl_pkg;

  localparam int NumSegment   = 2;
  localparam int RepWidth     = 16;
  localparam int SysTimeWidth = 56;
  localparam int GpioWidth    = 4;

  localparam logic [RepWidth-1:0] RepInfinite = 16'hFFFF;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_WAIT_TIME = 2'd2,
    ST_WAIT_GPIO = 2'd3
  } segment_ctl_state_t;

  // Unknown mode codes fall back to index-synchronous switching.
  function automatic segment_ctl_state_t wait_state_for(input logic [7:0] mode);
    segment_ctl_state_t st;
    case (mode)
      MODE_SYS_TIME: st = ST_WAIT_TIME;
      MODE_GPIO:     st = ST_WAIT_GPIO;
      default:       st = ST_WAIT_SYNC;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/segment_transition_ctl_if.sv
// Register-file / sampler side signals of the segment transition controller.
interface segment_transition_ctl_if;
  import segment_transition_ctl_pkg::*;

  logic                                 update;
  logic                                 req_segment;
  logic [7:0]                           transition_mode;
  logic [63:0]                          transition_value;
  logic [NumSegment-1:0][RepWidth-1:0]  rep;
  logic                                 loop_end;
  logic [SysTimeWidth-1:0]              sys_time;
  logic [GpioWidth-1:0]                 gpio_in;
  logic                                 segment;
  logic                                 swap;
  logic                                 stop;
  logic                                 waiting;

  modport master (
    output update, req_segment, transition_mode, transition_value, rep,
           loop_end, sys_time, gpio_in,
    input  segment, swap, stop, waiting
  );

  modport slave (
    input  update, req_segment, transition_mode, transition_value, rep,
           loop_end, sys_time, gpio_in,
    output segment, swap, stop, waiting
  );

endinterface

// File: rtl/segment_transition_ctl_gpio_edge_sync.sv
// Two-flop synchroniser for asynchronous GPIO pins followed by a rising-edge detector.
module gpio_edge_sync #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] pin_in,
  output logic [Width-1:0] rise
);

  logic [Width-1:0] sync1_r;
  logic [Width-1:0] sync2_r;
  logic [Width-1:0] prev_r;

  // Synchroniser chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
    end else begin
      sync1_r <= pin_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/segment_transition_ctl.sv
// Latches segment-change requests, waits for the selected trigger, swaps the read
// segment and counts loop repetitions (stop or auto-alternate in EXT mode).
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  segment_transition_ctl_if.slave  bus
);

  segment_ctl_state_t                  state_r;
  logic                                segment_r;
  logic                                swap_r;
  logic                                stop_r;
  logic                                waiting_r;
  logic                                ext_r;
  logic                                req_seg_r;
  logic [SysTimeWidth-1:0]             value_r;
  logic [NumSegment-1:0][RepWidth-1:0] rep_r;
  logic [RepWidth-1:0]                 loop_cnt_r;

  logic [GpioWidth-1:0] gpio_rise_s;
  logic [RepWidth-1:0]  cur_rep_s;
  logic                 count_active_s;
  logic                 rep_done_s;
  logic                 trig_s;
  logic                 target_s;

  gpio_edge_sync #(.Width(GpioWidth)) u_gpio_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (bus.gpio_in),
    .rise   (gpio_rise_s)
  );

  // Trigger detection for the current state and the segment it would switch to.
  always_comb begin
    cur_rep_s      = rep_r[segment_r];
    count_active_s = bus.loop_end && !stop_r && (cur_rep_s != RepInfinite);
    rep_done_s     = count_active_s && (loop_cnt_r == cur_rep_s);
    trig_s         = 1'b0;
    target_s       = segment_r;
    case (state_r)
      ST_RUN: begin
        trig_s   = rep_done_s && ext_r;
        target_s = ~segment_r;
      end
      ST_WAIT_SYNC: begin
        trig_s   = bus.loop_end;
        target_s = req_seg_r;
      end
      ST_WAIT_TIME: begin
        trig_s   = (bus.sys_time >= value_r);
        target_s = req_seg_r;
      end
      ST_WAIT_GPIO: begin
        trig_s   = gpio_rise_s[value_r[1:0]];
        target_s = req_seg_r;
      end
      default: begin
        trig_s   = 1'b0;
        target_s = segment_r;
      end
    endcase
  end

  // Main sequencer; UPDATE takes priority over any trigger in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      segment_r  <= 1'b0;
      swap_r     <= 1'b0;
      stop_r     <= 1'b0;
      waiting_r  <= 1'b0;
      ext_r      <= 1'b0;
      req_seg_r  <= 1'b0;
      value_r    <= '0;
      rep_r      <= {NumSegment{RepInfinite}};
      loop_cnt_r <= '0;
    end else begin
      swap_r <= 1'b0;
      if (bus.update) begin
        req_seg_r <= bus.req_segment;
        value_r   <= bus.transition_value[SysTimeWidth-1:0];
        rep_r     <= bus.rep;
        if (bus.transition_mode == MODE_EXT) begin
          segment_r  <= bus.req_segment;
          swap_r     <= (bus.req_segment != segment_r);
          loop_cnt_r <= '0;
          stop_r     <= 1'b0;
          ext_r      <= 1'b1;
          waiting_r  <= 1'b0;
          state_r    <= ST_RUN;
        end else if (bus.req_segment == segment_r) begin
          loop_cnt_r <= '0;
          stop_r     <= 1'b0;
          ext_r      <= 1'b0;
          waiting_r  <= 1'b0;
          state_r    <= ST_RUN;
        end else begin
          ext_r     <= 1'b0;
          waiting_r <= 1'b1;
          state_r   <= wait_state_for(bus.transition_mode);
        end
      end else if (trig_s) begin
        segment_r  <= target_s;
        swap_r     <= 1'b1;
        loop_cnt_r <= '0;
        stop_r     <= 1'b0;
        waiting_r  <= 1'b0;
        state_r    <= ST_RUN;
      end else if ((state_r == ST_RUN) && count_active_s) begin
        if (rep_done_s) begin
          stop_r <= 1'b1;
        end else begin
          loop_cnt_r <= loop_cnt_r + 16'd1;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.segment = segment_r;
  assign bus.swap    = swap_r;
  assign bus.stop    = stop_r;
  assign bus.waiting = waiting_r;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: triggers, repeat counting, EXT, collisions, reset.
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic saw_swap;

  segment_transition_ctl_if bus ();

  segment_transition_ctl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_update(input logic req, input logic [7:0] mode, input logic [63:0] value,
                           input logic [31:0] rep);
    bus.req_segment      = req;
    bus.transition_mode  = mode;
    bus.transition_value = value;
    bus.rep              = rep;
    bus.update           = 1'b1;
    tick();
    bus.update           = 1'b0;
  endtask

  task automatic pulse_loop_end();
    bus.loop_end = 1'b1;
    tick();
    bus.loop_end = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.update           = 1'b0;
    bus.req_segment      = 1'b0;
    bus.transition_mode  = 8'h00;
    bus.transition_value = 64'd0;
    bus.rep              = {16'hFFFF, 16'hFFFF};
    bus.loop_end         = 1'b0;
    bus.sys_time         = 56'd0;
    bus.gpio_in          = 4'b0000;
    tick();
    tick();
    check("rst_segment", {63'd0, bus.segment}, 64'd0);
    check("rst_swap",    {63'd0, bus.swap},    64'd0);
    check("rst_stop",    {63'd0, bus.stop},    64'd0);
    check("rst_waiting", {63'd0, bus.waiting}, 64'd0);
    rst_n = 1'b1;
    tick();

    // SYNC_IDX: swap the cycle after LOOP_END
    do_update(1'b1, 8'h00, 64'd0, {16'hFFFF, 16'hFFFF});
    check("sync_waiting", {63'd0, bus.waiting}, 64'd1);
    check("sync_seg_hold", {63'd0, bus.segment}, 64'd0);
    tick();
    tick();
    check("sync_still_wait", {63'd0, bus.waiting}, 64'd1);
    pulse_loop_end();
    check("sync_segment", {63'd0, bus.segment}, 64'd1);
    check("sync_swap", {63'd0, bus.swap}, 64'd1);
    check("sync_wait_clr", {63'd0, bus.waiting}, 64'd0);
    tick();
    check("sync_swap_1cyc", {63'd0, bus.swap}, 64'd0);

    // SYS_TIME: value 1000
    bus.sys_time = 56'd998;
    do_update(1'b0, 8'h01, 64'd1000, {16'hFFFF, 16'hFFFF});
    check("time_waiting", {63'd0, bus.waiting}, 64'd1);
    bus.sys_time = 56'd999;
    tick();
    check("time_early", {63'd0, bus.swap}, 64'd0);
    bus.sys_time = 56'd1000;
    tick();
    check("time_swap", {63'd0, bus.swap}, 64'd1);
    check("time_segment", {63'd0, bus.segment}, 64'd0);
    // time already passed
    bus.sys_time = 56'd900;
    do_update(1'b1, 8'h01, 64'd5, {16'hFFFF, 16'hFFFF});
    check("past_no_swap_on_update", {63'd0, bus.swap}, 64'd0);
    tick();
    check("past_swap", {63'd0, bus.swap}, 64'd1);
    check("past_segment", {63'd0, bus.segment}, 64'd1);

    // GPIO pin 2; pin 1 toggling is ignored
    do_update(1'b0, 8'h02, 64'd2, {16'hFFFF, 16'hFFFF});
    saw_swap = 1'b0;
    bus.gpio_in = 4'b0010;
    for (int i = 0; i < 4; i++) begin tick(); saw_swap |= bus.swap; end
    bus.gpio_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin tick(); saw_swap |= bus.swap; end
    check("gpio_other_pin", {63'd0, saw_swap}, 64'd0);
    check("gpio_waiting", {63'd0, bus.waiting}, 64'd1);
    bus.gpio_in = 4'b0100;
    tick();
    tick();
    check("gpio_lat2", {63'd0, bus.swap}, 64'd0);
    tick();
    check("gpio_lat3_swap", {63'd0, bus.swap}, 64'd1);
    check("gpio_segment", {63'd0, bus.segment}, 64'd0);
    // pin already high at UPDATE
    do_update(1'b1, 8'h02, 64'd2, {16'hFFFF, 16'hFFFF});
    saw_swap = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); saw_swap |= bus.swap; end
    check("gpio_high_no_trig", {63'd0, saw_swap}, 64'd0);
    bus.gpio_in = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    bus.gpio_in = 4'b0100;
    tick();
    tick();
    tick();
    check("gpio_reedge_swap", {63'd0, bus.swap}, 64'd1);
    check("gpio_reedge_seg", {63'd0, bus.segment}, 64'd1);
    bus.gpio_in = 4'b0000;

    // Finite repeat: REP[0]=2
    do_update(1'b0, 8'h00, 64'd0, {16'hFFFF, 16'd2});
    pulse_loop_end();
    check("rep_enter_seg0", {63'd0, bus.segment}, 64'd0);
    pulse_loop_end();
    tick();
    pulse_loop_end();
    check("rep_loop2_run", {63'd0, bus.stop}, 64'd0);
    tick();
    pulse_loop_end();
    check("rep_loop3_stop", {63'd0, bus.stop}, 64'd1);
    tick();
    pulse_loop_end();
    check("rep_loop4_stop", {63'd0, bus.stop}, 64'd1);
    check("rep_loop4_noswap", {63'd0, bus.swap}, 64'd0);
    do_update(1'b0, 8'h00, 64'd0, {16'hFFFF, 16'd2});
    check("rep_update_clr", {63'd0, bus.stop}, 64'd0);
    check("rep_update_nowait", {63'd0, bus.waiting}, 64'd0);

    // EXT: go to segment 1 first so the EXT request is a real change
    do_update(1'b1, 8'h00, 64'd0, {16'hFFFF, 16'hFFFF});
    pulse_loop_end();
    check("ext_pre_seg1", {63'd0, bus.segment}, 64'd1);
    do_update(1'b0, 8'hF0, 64'd0, {16'd0, 16'd1});
    check("ext_imm_swap", {63'd0, bus.swap}, 64'd1);
    check("ext_imm_seg", {63'd0, bus.segment}, 64'd0);
    for (int r = 0; r < 2; r++) begin
      tick();
      pulse_loop_end();
      check("ext_seg0_loop1", {62'd0, bus.swap, bus.segment}, 64'd0);
      tick();
      pulse_loop_end();
      check("ext_seg0_loop2", {62'd0, bus.swap, bus.segment}, 64'd3);
      tick();
      pulse_loop_end();
      check("ext_seg1_loop1", {62'd0, bus.swap, bus.segment}, 64'd2);
      check("ext_no_stop", {63'd0, bus.stop}, 64'd0);
    end

    // Collision: UPDATE wins over the pending LOOP_END
    do_update(1'b1, 8'h00, 64'd0, {16'hFFFF, 16'hFFFF});
    pulse_loop_end();
    check("col_pre_seg1", {63'd0, bus.segment}, 64'd1);
    do_update(1'b0, 8'h00, 64'd0, {16'hFFFF, 16'hFFFF});
    bus.loop_end = 1'b1;
    do_update(1'b0, 8'h00, 64'd0, {16'hFFFF, 16'hFFFF});
    bus.loop_end = 1'b0;
    check("col_no_swap", {62'd0, bus.swap, bus.segment}, 64'd1);
    check("col_pending", {63'd0, bus.waiting}, 64'd1);

    // Reset mid-wait
    rst_n = 1'b0;
    #2;
    check("midrst_outputs", {60'd0, bus.segment, bus.swap, bus.stop, bus.waiting}, 64'd0);
    tick();
    rst_n = 1'b1;
    saw_swap = 1'b0;
    tick();
    saw_swap |= bus.swap;
    pulse_loop_end();
    saw_swap |= bus.swap;
    for (int i = 0; i < 3; i++) begin tick(); saw_swap |= bus.swap; end
    check("postrst_no_swap", {63'd0, saw_swap}, 64'd0);
    check("postrst_state", {62'd0, bus.segment, bus.waiting}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
